apb_cmd_sched: RTL and testbench
================================

Name: apb_cmd_sched

Overview:
- Destination-clock-domain scheduler for the AXI-to-APB bridge.
- Arbitrates round-robin between the write-command and read-command FIFO outputs, which are the dst sides of the async FIFOs.
- Sequences one APB3 transfer at a time (SETUP/ACCESS with wait states and a timeout).
- Returns AXI-style responses into the write-response and read-response FIFOs, which are the src sides of the return FIFOs.

Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- ID_WIDTH, 4, AXI transaction ID width carried through
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready; 0 disables the timeout
- TO_CNT_WIDTH, ceilLog2(TIMEOUT_CYCLES+1) (min 1), derived timeout counter width

Ports:
- dst_clk  in  1  clock, shared with the FIFO dst/src sides in this domain
- dst_rst  in  1  reset, synchronous, active-high
- wr_cmd_vld  in  1  write command available
- wr_cmd_rdy  out  1  write command pop
- wr_cmd_data  in  ID_WIDTH+ADDR_WIDTH+DATA_WIDTH  {id, addr, wdata}
- rd_cmd_vld  in  1  read command available
- rd_cmd_rdy  out  1  read command pop
- rd_cmd_data  in  ID_WIDTH+ADDR_WIDTH  {id, addr}
- wr_rsp_vld  out  1  write response valid
- wr_rsp_rdy  in  1  write response FIFO ready
- wr_rsp_data  out  ID_WIDTH+2  {id, resp}
- rd_rsp_vld  out  1  read response valid
- rd_rsp_rdy  in  1  read response FIFO ready
- rd_rsp_data  out  ID_WIDTH+DATA_WIDTH+2  {id, rdata, resp}
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse when a transfer times out

Behaviour:
- Clock and reset: single clock dst_clk; dst_rst is synchronous, active-high. All state updates on the rising edge of dst_clk.
- Reset values:
  - state = IDLE
  - rr_last = read, so the write channel wins the first tie
  - psel, penable, pwrite = 0
  - paddr, pwdata = 0
  - wr_rsp_vld, rd_rsp_vld = 0; rsp data = 0
  - timeout_err = 0; timeout counter = 0
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grant is combinational.
  - Only one valid: grant it.
  - Both valid: grant the channel opposite rr_last.
  - The granted *_cmd_rdy is asserted combinationally, only in IDLE; at most one rdy is high per cycle.
  - On the handshake: register cmd fields, sel_wr, and set rr_last = granted channel, then go to SETUP.
  - Neither valid: stay in IDLE.
- SETUP (exactly 1 cycle): psel=1, penable=0; paddr, pwrite and pwdata (write only, else 0) are driven from registers. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite, pwdata are held stable.
  - pready=1: capture prdata (read) and resp = pslverr ? 2'b10 : 2'b00. Go to RESP; psel and penable drop at the next edge.
  - pready=0 with TIMEOUT_CYCLES != 0: the counter increments. When the counter equals TIMEOUT_CYCLES-1 and pready is still 0, abort: resp=2'b10, rdata=0, timeout_err pulses for 1 cycle, go to RESP.
  - The counter clears on entry to SETUP.
- RESP:
  - The selected *_rsp_vld is high with registered data; data is stable until the handshake.
  - On *_rsp_rdy: vld drops next cycle, go to IDLE.
  - Backpressure holds RESP indefinitely. No new command is popped while in RESP.
- Latency: minimum 4 cycles per transfer, from the cmd handshake edge to the response handshake with pready=1 and rsp_rdy=1. Throughput is 1 transfer per 4 cycles.
- Round-robin fairness: under continuous requests on both channels, grants strictly alternate W,R,W,R.
- Simultaneous events: a cmd vld arriving in a non-IDLE state waits. pslverr is sampled only when pready=1.
- Reset mid-transfer: psel and penable go low at the next edge and the in-flight command and response are discarded. The popped FIFO entry is lost; this is documented, and the bridge resets both sides together.
- Widths: the response code is 2 bits, AXI encoding; OKAY=00, SLVERR=10. There are no EXOKAY/DECERR sources.

Decomposition:
- Shared package axi2apb_pkg holds:
  - the state encoding
  - RESP_OKAY and RESP_SLVERR constants
  - cmd/rsp field offset localparams (id, addr, data positions)
  - the ceilLog2 function
- One natural sub-module: apb_rr_arb2. It is a 2-way round-robin grant with a registered last-winner pointer and a grant-update enable.

Test Plan:
- Single write: wr cmd {id=3, addr=0x10, wdata=0xA5A5_0001}, pready=1 → SETUP then ACCESS. Then wr_rsp {3, 00} appears 3 cycles after the pop, with pwdata=0xA5A5_0001.
- Read with waits: rd cmd {id=7, addr=0x20}, pready low for 5 cycles, prdata=0x1234_5678, pslverr=1 → rd_rsp {7, 0x1234_5678, 10}; paddr and psel are stable through all waits.
- Arbitration: both FIFOs continuously valid, 8 commands each → grant order W,R,W,R…; per-channel ID order is preserved.
- Timeout: TIMEOUT_CYCLES=4, pready=0 forever → after 4 ACCESS cycles, timeout_err pulses once and rsp resp=10, rdata=0. The next command proceeds normally.
- Backpressure: rd_rsp_rdy=0 for 10 cycles with a pending write cmd → no wr_cmd_rdy until the read rsp handshakes, then the write is issued.
- Reset mid-ACCESS: assert dst_rst during ACCESS → psel, penable, busy and rsp_vld are all 0 after the edge. After release, a write is granted first on a tie.

Source files
------------

// File: rtl/axi2apb_pkg.sv
// rtl/axi2apb_pkg.sv - shared types and constants for the AXI-to-APB bridge
//
// Purpose: scheduler state encoding, AXI response codes, command/response
// field offsets and the ceil_log2 helper used to size counters.
// Ports: none (package).

package axi2apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } sched_state_e;

   localparam int RESP_WIDTH = 2;
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

   // Fixed low-order field positions; the higher fields sit directly above
   // these and depend on the configured widths, so the modules derive them.
   localparam int WCMD_DATA_LSB = 0;   // {id, addr, wdata}
   localparam int RCMD_ADDR_LSB = 0;   // {id, addr}
   localparam int RSP_RESP_LSB  = 0;   // {id, resp} / {id, rdata, resp}
   localparam int RRSP_DATA_LSB = RESP_WIDTH;

   function automatic int ceil_log2(input int unsigned value);
      int r;
      r = 0;
      while ((longint'(1) << r) < longint'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// rtl/apb_rr_arb2.sv - two-way round-robin grant between write and read requests
//
// Purpose: grants one of two requesters; on a tie the side that did not win
// last time is chosen. A grant is taken as an accepted pop, so the last-winner
// pointer moves whenever a grant is issued.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   gnt_en          grants may be issued this cycle
//   req_wr, req_rd  requests
//   gnt_wr, gnt_rd  one-hot-or-zero combinational grants

module apb_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic gnt_en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);

   // 1 = read won last, so write wins the next tie
   logic last_rd_q;
   logic last_rd_d;

   always_comb begin
      gnt_wr    = gnt_en && req_wr && (!req_rd || last_rd_q);
      gnt_rd    = gnt_en && req_rd && (!req_wr || !last_rd_q);
      last_rd_d = last_rd_q;
      if (gnt_wr) begin
         last_rd_d = 1'b0;
      end else if (gnt_rd) begin
         last_rd_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_rd_q <= 1'b1;
      end else begin
         last_rd_q <= last_rd_d;
      end
   end

endmodule

// File: rtl/apb_cmd_sched.sv
// rtl/apb_cmd_sched.sv - APB3 transfer scheduler fed by write/read command FIFOs
//
// Purpose: pops one command at a time (round-robin between write and read),
// runs a single APB3 SETUP/ACCESS transfer with optional timeout, and pushes
// the AXI-style response into the matching response FIFO.
// Ports:
//   dst_clk, dst_rst                   clock, synchronous active-high reset
//   wr_cmd_vld/rdy/data                write command {id, addr, wdata}
//   rd_cmd_vld/rdy/data                read command {id, addr}
//   wr_rsp_vld/rdy/data                write response {id, resp}
//   rd_rsp_vld/rdy/data                read response {id, rdata, resp}
//   paddr, psel, penable, pwrite,
//   pwdata, prdata, pready, pslverr    APB3 master
//   busy                               scheduler not idle
//   timeout_err                        one-cycle pulse on an aborted transfer

module apb_cmd_sched
   import axi2apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_CNT_WIDTH   = (ceil_log2(TIMEOUT_CYCLES + 1) < 1) ? 1
                                           : ceil_log2(TIMEOUT_CYCLES + 1)
) (
   input  logic                                  dst_clk,
   input  logic                                  dst_rst,
   input  logic                                  wr_cmd_vld,
   output logic                                  wr_cmd_rdy,
   input  logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] wr_cmd_data,
   input  logic                                  rd_cmd_vld,
   output logic                                  rd_cmd_rdy,
   input  logic [ID_WIDTH+ADDR_WIDTH-1:0]        rd_cmd_data,
   output logic                                  wr_rsp_vld,
   input  logic                                  wr_rsp_rdy,
   output logic [ID_WIDTH+2-1:0]                 wr_rsp_data,
   output logic                                  rd_rsp_vld,
   input  logic                                  rd_rsp_rdy,
   output logic [ID_WIDTH+DATA_WIDTH+2-1:0]      rd_rsp_data,
   output logic [ADDR_WIDTH-1:0]                 paddr,
   output logic                                  psel,
   output logic                                  penable,
   output logic                                  pwrite,
   output logic [DATA_WIDTH-1:0]                 pwdata,
   input  logic [DATA_WIDTH-1:0]                 prdata,
   input  logic                                  pready,
   input  logic                                  pslverr,
   output logic                                  busy,
   output logic                                  timeout_err
);

   localparam int WCMD_ADDR_LSB = WCMD_DATA_LSB + DATA_WIDTH;
   localparam int WCMD_ID_LSB   = WCMD_ADDR_LSB + ADDR_WIDTH;
   localparam int RCMD_ID_LSB   = RCMD_ADDR_LSB + ADDR_WIDTH;

   // Last counter value before abort; unused when the timeout is disabled.
   localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
      TO_CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   sched_state_e                state_q, state_d;
   logic                        sel_wr_q, sel_wr_d;
   logic [ID_WIDTH-1:0]         id_q, id_d;
   logic [ADDR_WIDTH-1:0]       paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]       pwdata_q, pwdata_d;
   logic                        pwrite_q, pwrite_d;
   logic                        psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic [RESP_WIDTH-1:0]       resp_q, resp_d;
   logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
   logic [TO_CNT_WIDTH-1:0]     to_cnt_q, to_cnt_d;
   logic                        timeout_err_q, timeout_err_d;
   logic                        gnt_wr, gnt_rd;

   apb_rr_arb2 u_arb (
      .clk    (dst_clk),
      .rst    (dst_rst),
      .gnt_en (state_q == ST_IDLE),
      .req_wr (wr_cmd_vld),
      .req_rd (rd_cmd_vld),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );

   always_comb begin
      state_d       = state_q;
      sel_wr_d      = sel_wr_q;
      id_d          = id_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      resp_d        = resp_q;
      rdata_d       = rdata_q;
      to_cnt_d      = to_cnt_q;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_wr || gnt_rd) begin
               sel_wr_d = gnt_wr;
               to_cnt_d = '0;
               state_d  = ST_SETUP;
               if (gnt_wr) begin
                  id_d     = wr_cmd_data[WCMD_ID_LSB +: ID_WIDTH];
                  paddr_d  = wr_cmd_data[WCMD_ADDR_LSB +: ADDR_WIDTH];
                  pwdata_d = wr_cmd_data[WCMD_DATA_LSB +: DATA_WIDTH];
                  pwrite_d = 1'b1;
               end else begin
                  id_d     = rd_cmd_data[RCMD_ID_LSB +: ID_WIDTH];
                  paddr_d  = rd_cmd_data[RCMD_ADDR_LSB +: ADDR_WIDTH];
                  pwdata_d = '0;
                  pwrite_d = 1'b0;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               resp_d  = pslverr ? RESP_SLVERR : RESP_OKAY;
               rdata_d = sel_wr_q ? '0 : prdata;
               state_d = ST_RESP;
            end else if (TIMEOUT_CYCLES != 0) begin
               if (to_cnt_q == TO_LAST) begin
                  resp_d        = RESP_SLVERR;
                  rdata_d       = '0;
                  timeout_err_d = 1'b1;
                  state_d       = ST_RESP;
               end else begin
                  to_cnt_d = to_cnt_q + TO_CNT_WIDTH'(1);
               end
            end
         end
         ST_RESP: begin
            if ((sel_wr_q && wr_rsp_rdy) || (!sel_wr_q && rd_rsp_rdy)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // APB strobes are registered from the next state so they change on the
      // same edge as the state itself.
      psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d = (state_d == ST_ACCESS);
   end

   always_ff @(posedge dst_clk) begin
      if (dst_rst) begin
         state_q       <= ST_IDLE;
         sel_wr_q      <= 1'b0;
         id_q          <= '0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         resp_q        <= '0;
         rdata_q       <= '0;
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_wr_q      <= sel_wr_d;
         id_q          <= id_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         resp_q        <= resp_d;
         rdata_q       <= rdata_d;
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign wr_cmd_rdy  = gnt_wr;
   assign rd_cmd_rdy  = gnt_rd;
   assign wr_rsp_vld  = (state_q == ST_RESP) && sel_wr_q;
   assign rd_rsp_vld  = (state_q == ST_RESP) && !sel_wr_q;
   assign wr_rsp_data = {id_q, resp_q};
   assign rd_rsp_data = {id_q, rdata_q, resp_q};
   assign paddr       = paddr_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_apb_cmd_sched.sv
// tb/tb_apb_cmd_sched.sv - self-checking bench for apb_cmd_sched

module tb_apb_cmd_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_cmd_vld, rd_cmd_vld, wr_rsp_rdy, rd_rsp_rdy;
   logic [67:0] wr_cmd_data;
   logic [35:0] rd_cmd_data;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        wr_cmd_rdy, rd_cmd_rdy, wr_rsp_vld, rd_rsp_vld;
   logic [5:0]  wr_rsp_data;
   logic [37:0] rd_rsp_data;
   logic [31:0] paddr, pwdata;
   logic        psel, penable, pwrite, busy, timeout_err;

   // second instance with a short timeout, read channel only
   logic        rd_cmd_vld_to, pready_to;
   logic        wr_cmd_rdy_to, rd_cmd_rdy_to, wr_rsp_vld_to, rd_rsp_vld_to;
   logic [5:0]  wr_rsp_data_to;
   logic [37:0] rd_rsp_data_to;
   logic [31:0] paddr_to, pwdata_to;
   logic        psel_to, penable_to, pwrite_to, busy_to, timeout_err_to;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   apb_cmd_sched dut (
      .dst_clk(clk), .dst_rst(rst),
      .wr_cmd_vld(wr_cmd_vld), .wr_cmd_rdy(wr_cmd_rdy), .wr_cmd_data(wr_cmd_data),
      .rd_cmd_vld(rd_cmd_vld), .rd_cmd_rdy(rd_cmd_rdy), .rd_cmd_data(rd_cmd_data),
      .wr_rsp_vld(wr_rsp_vld), .wr_rsp_rdy(wr_rsp_rdy), .wr_rsp_data(wr_rsp_data),
      .rd_rsp_vld(rd_rsp_vld), .rd_rsp_rdy(rd_rsp_rdy), .rd_rsp_data(rd_rsp_data),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .busy(busy), .timeout_err(timeout_err)
   );

   apb_cmd_sched #(.TIMEOUT_CYCLES(4)) dut_to (
      .dst_clk(clk), .dst_rst(rst),
      .wr_cmd_vld(1'b0), .wr_cmd_rdy(wr_cmd_rdy_to), .wr_cmd_data(wr_cmd_data),
      .rd_cmd_vld(rd_cmd_vld_to), .rd_cmd_rdy(rd_cmd_rdy_to), .rd_cmd_data(rd_cmd_data),
      .wr_rsp_vld(wr_rsp_vld_to), .wr_rsp_rdy(1'b1), .wr_rsp_data(wr_rsp_data_to),
      .rd_rsp_vld(rd_rsp_vld_to), .rd_rsp_rdy(1'b1), .rd_rsp_data(rd_rsp_data_to),
      .paddr(paddr_to), .psel(psel_to), .penable(penable_to), .pwrite(pwrite_to),
      .pwdata(pwdata_to), .prdata(prdata), .pready(pready_to), .pslverr(pslverr),
      .busy(busy_to), .timeout_err(timeout_err_to)
   );

   // in: {wr_cmd_vld, rd_cmd_vld, pready, pslverr, wr_rsp_rdy, rd_rsp_rdy}
   // ex: {wr_cmd_rdy, rd_cmd_rdy, psel, penable, pwrite, wr_rsp_vld, rd_rsp_vld, busy}
   typedef struct {
      logic [5:0]  in;
      logic [7:0]  ex;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [37:0] rsp;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic [5:0] i, logic [7:0] e, logic [31:0] a,
                               logic [31:0] d, logic [37:0] r);
      vec_t v;
      v.in = i; v.ex = e; v.addr = a; v.wdata = d; v.rsp = r;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {wr_cmd_rdy, rd_cmd_rdy, psel, penable, pwrite, wr_rsp_vld, rd_rsp_vld, busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int wi, ri, gcnt, wrsp, rrsp, n, acc, tcnt, seen;
      logic [37:0] rd_exp;

      rst = 1'b1;
      wr_cmd_vld = 0; rd_cmd_vld = 0; wr_rsp_rdy = 1; rd_rsp_rdy = 1;
      pready = 0; pslverr = 0; rd_cmd_vld_to = 0; pready_to = 0;
      wr_cmd_data = {4'h3, 32'h0000_0010, 32'hA5A5_0001};
      rd_cmd_data = {4'h7, 32'h0000_0020};
      prdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single write, then a read with 5 wait states, pslverr and one cycle of rsp backpressure
      rd_exp = {4'h7, 32'h1234_5678, 2'b10};
      vecs[0]  = mk(6'b000011, 8'b0000_0000, 32'h0,  32'h0,          38'h0);
      vecs[1]  = mk(6'b101011, 8'b1000_0000, 32'h0,  32'h0,          38'h0);
      vecs[2]  = mk(6'b001011, 8'b0010_1001, 32'h10, 32'hA5A5_0001,  38'h0);
      vecs[3]  = mk(6'b001011, 8'b0011_1001, 32'h10, 32'hA5A5_0001,  38'h0);
      vecs[4]  = mk(6'b001011, 8'b0000_1101, 32'h10, 32'hA5A5_0001,  38'h0C);
      vecs[5]  = mk(6'b010111, 8'b0100_1000, 32'h10, 32'hA5A5_0001,  38'h0);
      vecs[6]  = mk(6'b000111, 8'b0010_0001, 32'h20, 32'h0,          38'h0);
      for (int k = 7; k <= 11; k++)
         vecs[k] = mk(6'b000111, 8'b0011_0001, 32'h20, 32'h0, 38'h0);
      vecs[12] = mk(6'b001111, 8'b0011_0001, 32'h20, 32'h0,          38'h0);
      vecs[13] = mk(6'b001110, 8'b0000_0011, 32'h20, 32'h0,          rd_exp);
      vecs[14] = mk(6'b001111, 8'b0000_0011, 32'h20, 32'h0,          rd_exp);
      vecs[15] = mk(6'b000011, 8'b0000_0000, 32'h20, 32'h0,          38'h0);

      for (int k = 0; k < 16; k++) begin
         tick();
         {wr_cmd_vld, rd_cmd_vld, pready, pslverr, wr_rsp_rdy, rd_rsp_rdy} = vecs[k].in;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", k), 64'(outs()), 64'(vecs[k].ex));
         chk($sformatf("vec%0d_paddr", k), 64'(paddr), 64'(vecs[k].addr));
         chk($sformatf("vec%0d_pwdata", k), 64'(pwdata), 64'(vecs[k].wdata));
         if (vecs[k].ex[1]) chk($sformatf("vec%0d_rdrsp", k), 64'(rd_rsp_data), 64'(vecs[k].rsp));
         if (vecs[k].ex[2]) chk($sformatf("vec%0d_wrrsp", k), 64'(wr_rsp_data), 64'(vecs[k].rsp));
         if (k == 0) chk("reset_timeout_err", 64'(timeout_err), 64'h0);
      end

      // arbitration: both channels continuously valid, 8 commands each
      wi = 0; ri = 0; gcnt = 0; wrsp = 0; rrsp = 0; n = 0;
      pready = 1; pslverr = 0; wr_rsp_rdy = 1; rd_rsp_rdy = 1;
      while ((wrsp < 8 || rrsp < 8) && n < 300) begin
         tick();
         wr_cmd_vld  = (wi < 8);
         wr_cmd_data = {4'(wi), 32'h100 + 32'(wi) * 4, 32'hD000 + 32'(wi)};
         rd_cmd_vld  = (ri < 8);
         rd_cmd_data = {4'(ri), 32'h200 + 32'(ri) * 4};
         @(negedge clk);
         if (wr_cmd_rdy && rd_cmd_rdy) chk("arb_both_rdy", 64'h1, 64'h0);
         if (wr_cmd_rdy) begin
            chk("arb_order", 64'h0, 64'(gcnt % 2));
            wi++; gcnt++;
         end else if (rd_cmd_rdy) begin
            chk("arb_order", 64'h1, 64'(gcnt % 2));
            ri++; gcnt++;
         end
         if (wr_rsp_vld) begin
            chk("arb_wr_id", 64'(wr_rsp_data[5:2]), 64'(wrsp));
            wrsp++;
         end
         if (rd_rsp_vld) begin
            chk("arb_rd_id", 64'(rd_rsp_data[37:34]), 64'(rrsp));
            rrsp++;
         end
         n++;
      end
      if (n >= 300) chk("arb_timeout", 64'(wrsp + rrsp), 64'd16);

      // backpressure: read response held, pending write must not be popped
      tick();
      wr_cmd_vld = 0; rd_cmd_vld = 1; rd_cmd_data = {4'h5, 32'h30};
      rd_rsp_rdy = 0; prdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("bp_rd_pop", 64'(rd_cmd_rdy), 64'h1);
      for (int k = 0; k < 10; k++) begin
         tick();
         rd_cmd_vld = 0; wr_cmd_vld = 1;
         wr_cmd_data = {4'h6, 32'h40, 32'hCAFE_0006};
         @(negedge clk);
         chk($sformatf("bp_no_wr_rdy%0d", k), 64'(wr_cmd_rdy), 64'h0);
      end
      tick();
      rd_rsp_rdy = 1;
      @(negedge clk);
      chk("bp_rd_rsp", 64'({rd_rsp_vld, wr_cmd_rdy, rd_rsp_data}),
          64'({1'b1, 1'b0, 4'h5, 32'h5555_AAAA, 2'b00}));
      tick();
      @(negedge clk);
      chk("bp_wr_pop", 64'(wr_cmd_rdy), 64'h1);
      tick();
      wr_cmd_vld = 0;
      n = 0;
      while (!wr_rsp_vld && n < 10) begin
         @(negedge clk);
         if (!wr_rsp_vld) begin
            tick();
            n++;
         end
      end
      chk("bp_wr_rsp", 64'({wr_rsp_vld, wr_rsp_data, pwdata}), 64'({1'b1, 4'h6, 2'b00, 32'hCAFE_0006}));

      // reset during ACCESS of a write; afterwards a tie must go to write
      tick();
      wr_cmd_vld = 1; rd_cmd_vld = 0; pready = 0;
      @(negedge clk);
      chk("rst_wr_pop", 64'(wr_cmd_rdy), 64'h1);
      tick();
      wr_cmd_vld = 0;
      tick();
      @(negedge clk);
      chk("rst_in_access", 64'({psel, penable}), 64'h3);
      tick();
      rst = 1;
      tick();
      @(negedge clk);
      chk("rst_outputs", 64'({psel, penable, busy, wr_rsp_vld, rd_rsp_vld}), 64'h0);
      tick();
      rst = 0; wr_cmd_vld = 1; rd_cmd_vld = 1; pready = 1;
      @(negedge clk);
      chk("rst_tie_wr_first", 64'({wr_cmd_rdy, rd_cmd_rdy}), 64'h2);
      tick();
      wr_cmd_vld = 0; rd_cmd_vld = 0;

      // timeout on the TIMEOUT_CYCLES=4 instance, then a normal read
      tick();
      rd_cmd_vld_to = 1; rd_cmd_data = {4'h9, 32'h50};
      prdata = 32'hDEAD_BEEF; pready_to = 0; pslverr = 0;
      @(negedge clk);
      chk("to_pop", 64'(rd_cmd_rdy_to), 64'h1);
      acc = 0; tcnt = 0; seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         rd_cmd_vld_to = 0;
         @(negedge clk);
         if (penable_to) acc++;
         if (timeout_err_to) tcnt++;
         if (rd_rsp_vld_to) begin
            seen++;
            chk("to_rsp", 64'({timeout_err_to, rd_rsp_data_to}), 64'({1'b1, 4'h9, 32'h0, 2'b10}));
         end
      end
      chk("to_access_cycles", 64'(acc), 64'd4);
      chk("to_pulses", 64'(tcnt), 64'd1);
      chk("to_rsp_count", 64'(seen), 64'd1);

      tick();
      rd_cmd_vld_to = 1; rd_cmd_data = {4'hA, 32'h60};
      prdata = 32'h0BAD_F00D; pready_to = 1;
      @(negedge clk);
      chk("to_next_pop", 64'(rd_cmd_rdy_to), 64'h1);
      tcnt = 0; seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         rd_cmd_vld_to = 0;
         @(negedge clk);
         if (timeout_err_to) tcnt++;
         if (rd_rsp_vld_to) begin
            seen++;
            chk("to_next_rsp", 64'(rd_rsp_data_to), 64'({4'hA, 32'h0BAD_F00D, 2'b00}));
         end
      end
      chk("to_next_pulses", 64'(tcnt), 64'd0);
      chk("to_next_rsp_count", 64'(seen), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
